// File: rtl/score_award_queue.sv
// Turns brick hits into metered one-hot +1/+2/+3 award pulses for the ones-digit counter.
// Latency: 1 cycle on the empty-queue bypass; queued awards leave every 1+GAP_CYCLES cycles.
// Backpressure: none upstream; hits beyond DEPTH queued awards are dropped with an overflow pulse.
module score_award_queue #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   game_active,
    input  logic                   hit_valid,
    input  logic [2:0]             hit_row,
    output logic                   pOne,
    output logic                   pTwo,
    output logic                   pThree,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] GAP_LOAD = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    gap_q, gap_d;
    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    award_q, award_d;
    logic          ovf_q, ovf_d;

    logic [1:0] hit_pts;
    logic       ready;
    logic       do_pop;
    logic       do_push;
    logic       bypass;

    function automatic logic [2:0] decode(input logic [1:0] code);
        case (code)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign hit_pts = (hit_row < 3'd2) ? 2'b11 : (hit_row < 3'd4) ? 2'b10 : 2'b01;

    // The final gap cycle and a zero-gap EMIT both act as IDLE, giving a 1+GAP_CYCLES pulse period.
    assign ready = (state_q == IDLE)
                || ((state_q == EMIT) && (GAP_CYCLES == 0))
                || ((state_q == GAP) && (gap_q == 3'd0));

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        award_d  = 3'b000;
        ovf_d    = 1'b0;
        do_pop   = 1'b0;
        do_push  = 1'b0;
        bypass   = 1'b0;
        if (!game_active) begin
            state_d  = IDLE;
            gap_d    = 3'd0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (ready) begin
                if (cnt_q != '0) begin
                    do_pop   = 1'b1;
                    award_d  = decode(mem_q[rd_ptr_q]);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    state_d  = EMIT;
                end else if (hit_valid) begin
                    bypass  = 1'b1;
                    award_d = decode(hit_pts);
                    state_d = EMIT;
                end else begin
                    state_d = IDLE;
                end
            end else if (state_q == EMIT) begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
            end else begin
                gap_d = gap_q - 3'd1;
            end
            // A same-edge pop frees the slot, so a full queue still accepts the hit.
            if (hit_valid && !bypass) begin
                if (do_pop || (cnt_q != CW'(DEPTH))) begin
                    do_push         = 1'b1;
                    mem_d[wr_ptr_q] = hit_pts;
                    wr_ptr_d        = wr_ptr_q + AW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gap_q    <= 3'd0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            award_q  <= 3'b000;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            award_q  <= award_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign pOne     = award_q[0];
    assign pTwo     = award_q[1];
    assign pThree   = award_q[2];
    assign overflow = ovf_q;
    assign pending  = cnt_q;

endmodule

// File: tb/tb_score_award_queue.sv
// Bench for score_award_queue: two instances (gap 1 and gap 7) share random and directed stimulus.
module tb_score_award_queue;
    localparam int DEPTH = 4;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       game_active = 1'b0;
    logic       hit_valid   = 1'b0;
    logic [2:0] hit_row     = 3'd0;

    logic       g1_one, g1_two, g1_three, g1_ovf;
    logic [2:0] g1_pend;
    logic       g7_one, g7_two, g7_three, g7_ovf;
    logic [2:0] g7_pend;

    int checks   = 0;
    int failures = 0;
    int awd_cnt [2];
    int ovf_cnt [2];

    // Reference: a queue of point codes plus a cooldown until the next award may leave.
    logic [1:0] mq [2][DEPTH];
    int         mcnt [2]   = '{0, 0};
    int         mwl [2]    = '{0, 0};
    logic [2:0] exp_aw [2] = '{3'b000, 3'b000};
    logic       exp_ovf [2] = '{1'b0, 1'b0};

    score_award_queue #(.DEPTH(DEPTH), .GAP_CYCLES(1)) u_g1 (
        .clk(clk), .reset(rst_n), .game_active(game_active), .hit_valid(hit_valid),
        .hit_row(hit_row), .pOne(g1_one), .pTwo(g1_two), .pThree(g1_three),
        .overflow(g1_ovf), .pending(g1_pend)
    );

    score_award_queue #(.DEPTH(DEPTH), .GAP_CYCLES(7)) u_g7 (
        .clk(clk), .reset(rst_n), .game_active(game_active), .hit_valid(hit_valid),
        .hit_row(hit_row), .pOne(g7_one), .pTwo(g7_two), .pThree(g7_three),
        .overflow(g7_ovf), .pending(g7_pend)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] dut_aw(input int i);
        return (i == 0) ? {g1_three, g1_two, g1_one} : {g7_three, g7_two, g7_one};
    endfunction

    function automatic logic [1:0] pts(input logic [2:0] row);
        if (row < 3'd2) return 2'd3;
        if (row < 3'd4) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] p);
        case (p)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int   gap;
        logic take;
        gap        = (i == 0) ? 1 : 7;
        exp_aw[i]  = 3'b000;
        exp_ovf[i] = 1'b0;
        if (!game_active) begin
            mcnt[i] = 0;
            mwl[i]  = 0;
        end else begin
            take = hit_valid;
            if (mwl[i] == 0) begin
                if (mcnt[i] > 0) begin
                    exp_aw[i] = onehot(mq[i][0]);
                    for (int j = 0; j < DEPTH - 1; j++) mq[i][j] = mq[i][j+1];
                    mcnt[i]--;
                    mwl[i] = gap;
                end else if (hit_valid) begin
                    exp_aw[i] = onehot(pts(hit_row));
                    take      = 1'b0;
                    mwl[i]    = gap;
                end
            end else begin
                mwl[i]--;
            end
            if (take) begin
                if (mcnt[i] < DEPTH) begin
                    mq[i][mcnt[i]] = pts(hit_row);
                    mcnt[i]++;
                end else begin
                    exp_ovf[i] = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mcnt[i]    = 0;
                mwl[i]     = 0;
                exp_aw[i]  = 3'b000;
                exp_ovf[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    always @(negedge clk) begin
        chk("g1_award",   int'(dut_aw(0)), int'(exp_aw[0]));
        chk("g1_ovf",     int'(g1_ovf),    int'(exp_ovf[0]));
        chk("g1_pending", int'(g1_pend),   mcnt[0]);
        chk("g7_award",   int'(dut_aw(1)), int'(exp_aw[1]));
        chk("g7_ovf",     int'(g7_ovf),    int'(exp_ovf[1]));
        chk("g7_pending", int'(g7_pend),   mcnt[1]);
    end

    task automatic step(input logic v, input logic [2:0] r, input logic act);
        hit_valid   = v;
        hit_row     = r;
        game_active = act;
        @(posedge clk);
        #1;
        hit_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            awd_cnt[i] += int'(|dut_aw(i));
            ovf_cnt[i] += int'((i == 0) ? g1_ovf : g7_ovf);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'd0, 1'b1);
    endtask

    initial begin
        int dens;
        awd_cnt = '{0, 0};
        ovf_cnt = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_award",   int'(dut_aw(0)), 0);
        chk("reset_ovf",     int'(g1_ovf),    0);
        chk("reset_pending", int'(g7_pend),   0);
        rst_n = 1'b1;
        idle(2);

        step(1'b1, 3'd5, 1'b1);
        chk("single_pone", int'(dut_aw(0)), 3'b001);
        step(1'b0, 3'd0, 1'b1);
        chk("single_low", int'(dut_aw(0)), 3'b000);
        idle(2);
        step(1'b1, 3'd1, 1'b1);
        chk("single_pthree", int'(dut_aw(0)), 3'b100);
        idle(12);

        step(1'b1, 3'd0, 1'b1);
        chk("burst_a", int'(dut_aw(0)), 3'b100);
        step(1'b1, 3'd2, 1'b1);
        chk("burst_gap", int'(dut_aw(0)), 3'b000);
        chk("burst_pend1", int'(g1_pend), 1);
        step(1'b1, 3'd7, 1'b1);
        chk("burst_b", int'(dut_aw(0)), 3'b010);
        chk("burst_pend2", int'(g1_pend), 1);
        step(1'b0, 3'd0, 1'b1);
        chk("burst_gap2", int'(dut_aw(0)), 3'b000);
        step(1'b0, 3'd0, 1'b1);
        chk("burst_c", int'(dut_aw(0)), 3'b001);
        chk("burst_pend0", int'(g1_pend), 0);
        idle(40);

        awd_cnt[1] = 0;
        ovf_cnt[1] = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 1'b1);
            if (i == 0) chk("ovf_bypass_uncounted", int'(g7_pend), 0);
            if (i == 4) chk("ovf_full", int'(g7_pend), 4);
            if (i == 5) chk("ovf_first", int'(g7_ovf), 1);
        end
        idle(40);
        chk("ovf_awards", awd_cnt[1], 5);
        chk("ovf_drops",  ovf_cnt[1], 2);

        step(1'b1, 3'd4, 1'b1);
        step(1'b1, 3'd0, 1'b1);
        step(1'b1, 3'd2, 1'b1);
        step(1'b1, 3'd3, 1'b1);
        step(1'b1, 3'd6, 1'b1);
        chk("pp_fill", int'(g7_pend), 4);
        idle(3);
        step(1'b1, 3'd7, 1'b1);
        chk("pp_pending", int'(g7_pend), 4);
        chk("pp_no_ovf",  int'(g7_ovf),  0);
        chk("pp_award",   int'(dut_aw(1)), 3'b100);
        idle(40);

        step(1'b1, 3'd3, 1'b1);
        step(1'b1, 3'd1, 1'b1);
        step(1'b1, 3'd5, 1'b1);
        step(1'b1, 3'd7, 1'b1);
        chk("flush_pre", int'(g7_pend), 3);
        step(1'b0, 3'd0, 1'b0);
        chk("flush_g7_pend", int'(g7_pend), 0);
        chk("flush_g1_pend", int'(g1_pend), 0);
        awd_cnt = '{0, 0};
        ovf_cnt = '{0, 0};
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 1'b0);
        idle(12);
        chk("flush_g1_awards", awd_cnt[0], 0);
        chk("flush_g7_awards", awd_cnt[1], 0);
        chk("flush_g7_ovf",    ovf_cnt[1], 0);

        step(1'b1, 3'd3, 1'b1);
        chk("rst_ptwo", int'(dut_aw(0)), 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_drop", int'(dut_aw(0)), 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_pend_g1", int'(g1_pend), 0);
        chk("rst_pend_g7", int'(g7_pend), 0);
        step(1'b1, 3'd6, 1'b1);
        chk("rst_bypass", int'(dut_aw(0)), 3'b001);
        idle(4);

        dens = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) dens = (c % 600 == 0) ? 20 : (c % 600 == 200) ? 50 : 90;
            step(1'($urandom_range(0, 99) < dens), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 59) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/score_award_queue.md
# score_award_queue

Upstream stage of the ones-digit score counter: converts brick-hit events from the collision logic into one-hot `pOne`/`pTwo`/`pThree` pulses. Hits can arrive in consecutive cycles, but the counter must see exactly one award per pulse with guaranteed idle spacing. This block therefore buffers hits in a small FIFO and meters them out one at a time. It runs on the same difficulty-scaled game clock as the score digits.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, 2..16).
- `GAP_CYCLES`, 1: idle cycles forced after each award pulse (0..7).
- `clk` input 1: game clock (difficulty-scaled).
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `game_active` input 1: high while the ball is in play. Low flushes pending awards.
- `hit_valid` input 1: single-cycle brick-hit strobe.
- `hit_row` input 3: row of the struck brick. Row 0 is the top row.
- `pOne` output 1: award +1 pulse to the ones-digit counter.
- `pTwo` output 1: award +2 pulse.
- `pThree` output 1: award +3 pulse.
- `overflow` output 1: one-cycle pulse when a hit is dropped because the FIFO is full.
- `pending` output $clog2(DEPTH)+1: number of queued awards.

## Operation
- Point map, applied at capture:
  - rows 0–1 → 3 points.
  - rows 2–3 → 2 points.
  - rows 4–7 → 1 point.
  - Each entry is stored as a 2-bit code (01, 10, 11).
- FSM states: `IDLE`, `EMIT`, `GAP`.
  - `IDLE`:
    - FIFO non-empty → pop the head and go to `EMIT`.
    - Else, if `hit_valid`, bypass the FIFO: emit that hit directly and go to `EMIT`.
    - Else stay in `IDLE`.
  - `EMIT` (exactly one cycle; one award output high):
    - `GAP_CYCLES`>0 → go to `GAP` and load the gap counter.
    - `GAP_CYCLES`=0 → behave as `IDLE` on this edge (back-to-back pulses allowed).
  - `GAP`: the counter decrements each cycle. On reaching 0, go to `IDLE`.
- A hit not consumed by the `IDLE` bypass is pushed into the FIFO.
- A push and a pop on the same edge are both honored, including when the FIFO is full: the pop frees the slot the push uses.
- Full FIFO with a push and no pop: the hit is dropped, `overflow` pulses, and `pending` is unchanged.
- At most one of `pOne`/`pTwo`/`pThree` is high in any cycle. All three are low outside `EMIT`.
- `game_active` low, sampled at an edge:
  - FIFO emptied; `pending` → 0.
  - FSM → `IDLE`; gap counter cleared.
  - Award outputs low from the next cycle.
  - Hits while inactive are ignored and never cause `overflow`.
- `hit_row` values are all legal. No X-propagation is allowed from an unused FIFO slot.

## Timing
- All outputs are registered.
- Reset values: `pOne`=`pTwo`=`pThree`=0, `overflow`=0, `pending`=0. FSM in `IDLE`, FIFO pointers 0.
- Reset is asynchronous on assert and synchronous on release. Reset mid-pulse drops the pulse immediately, and all queued awards are lost.
- Latency, bypass path: hit sampled at edge k with the FSM in `IDLE` and the FIFO empty → award output high from edge k to edge k+1.
- Latency, queued path: the pulse appears one cycle after the FSM reaches `IDLE` with the entry at the FIFO head.
- Pulse period with a continuous backlog: 1+`GAP_CYCLES` cycles.
- `pending` reflects FIFO occupancy after the edge. A bypassed hit is never counted.
- `overflow` is high for the single cycle following the edge on which the drop occurred.
- Awards are emitted in hit order (FIFO order). The bypass path applies only when the FIFO is empty, so ordering holds.

## Test plan
- Reset and single hits: release reset; a single hit on row 5 → `pOne` high one cycle after the hit edge, then all low. A later hit on row 1 → `pThree` one cycle.
- Burst, `GAP_CYCLES`=1: hits on rows 0, 2, 7 in 3 consecutive cycles → `pThree`, `pTwo`, `pOne` pulses at cycles 1, 3, 5 after the first hit. `pending` peaks at 1.
- Overflow, `DEPTH`=4, `GAP_CYCLES`=7: 7 consecutive hits → 1 bypassed, 4 queued, first `overflow` pulse on the 6th hit. Exactly 5 awards are emitted over the following 40 cycles.
- Full FIFO with simultaneous push and pop: fill to 4 and align a hit with the pop edge → no `overflow`; `pending` stays 4.
- Flush: queue 3 awards, drop `game_active` for 1 cycle → `pending`=0, and no further award pulses. Hits during inactive → no pulse, no `overflow`.
- Async reset mid-`EMIT`: assert `reset` low between edges while `pTwo` is high → `pTwo` falls immediately. After release, `pending`=0 and the next hit bypasses with 1-cycle latency.
